// File: rtl/tcp_tx_packetizer_if.sv
// rtl/tcp_tx_packetizer_if.sv - command, payload, network_top tx and completion streams of the packetizer
interface tcp_tx_packetizer_if;
    logic         s_cmd_valid;
    logic         s_cmd_ready;
    logic [47:0]  s_cmd_data;

    logic         s_payload_valid;
    logic         s_payload_ready;
    logic [511:0] s_payload_data;

    logic         m_tx_meta_valid;
    logic         m_tx_meta_ready;
    logic [31:0]  m_tx_meta_data;

    logic         s_tx_status_valid;
    logic         s_tx_status_ready;
    logic [63:0]  s_tx_status_data;

    logic         m_tx_data_valid;
    logic         m_tx_data_ready;
    logic [511:0] m_tx_data_data;
    logic [63:0]  m_tx_data_keep;
    logic         m_tx_data_last;

    logic         m_done_valid;
    logic         m_done_ready;
    logic [63:0]  m_done_data;

    modport master (
        input  s_cmd_valid, s_cmd_data,
        output s_cmd_ready,
        input  s_payload_valid, s_payload_data,
        output s_payload_ready,
        output m_tx_meta_valid, m_tx_meta_data,
        input  m_tx_meta_ready,
        input  s_tx_status_valid, s_tx_status_data,
        output s_tx_status_ready,
        output m_tx_data_valid, m_tx_data_data, m_tx_data_keep, m_tx_data_last,
        input  m_tx_data_ready,
        output m_done_valid, m_done_data,
        input  m_done_ready
    );

    modport slave (
        output s_cmd_valid, s_cmd_data,
        input  s_cmd_ready,
        output s_payload_valid, s_payload_data,
        input  s_payload_ready,
        input  m_tx_meta_valid, m_tx_meta_data,
        output m_tx_meta_ready,
        output s_tx_status_valid, s_tx_status_data,
        input  s_tx_status_ready,
        input  m_tx_data_valid, m_tx_data_data, m_tx_data_keep, m_tx_data_last,
        output m_tx_data_ready,
        input  m_done_valid, m_done_data,
        output m_done_ready
    );
endinterface

// File: rtl/tcp_tx_packetizer.sv
// rtl/tcp_tx_packetizer.sv - splits a transfer command into TCP packets with status wait, retry and drain
module tcp_tx_packetizer #(
    parameter int MAX_PKT      = 1408,
    parameter int RETRY_CYCLES = 1024,
    parameter int MAX_RETRIES  = 255
) (
    input logic                 aclk,
    input logic                 aresetn,
    tcp_tx_packetizer_if.master bus
);
    localparam int BW = (RETRY_CYCLES > 2) ? $clog2(RETRY_CYCLES) : 1;
    localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_META, S_STATUS, S_WAIT, S_DATA, S_DRAIN, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     session_q;
    logic [31:0]     remaining_q;
    logic [31:0]     sent_q;
    logic [15:0]     pkt_len_q;
    logic [RW-1:0]   retry_q;
    logic [BW-1:0]   backoff_q;
    logic [9:0]      beats_q;
    logic [9:0]      beat_cnt_q;
    logic [2:0]      err_q;

    // Handshake flags are registered so every valid/ready is low during and right after reset.
    logic cmd_ready_q, meta_valid_q, status_ready_q, data_q, drain_q, done_valid_q;

    logic [31:0]   cmd_total;
    logic [2:0]    st_code;
    logic [RW-1:0] retry_inc;
    logic          payload_ready;
    logic          cmd_hs, meta_hs, st_hs, pay_hs, done_hs;
    logic          last_beat;
    logic          status_unused;

    function automatic logic [15:0] clip_len(input logic [31:0] r);
        return (r > 32'(MAX_PKT)) ? 16'(MAX_PKT) : r[15:0];
    endfunction

    assign cmd_total     = bus.s_cmd_data[47:16];
    assign st_code       = bus.s_tx_status_data[63:61];
    // Session and length echoed in the status are not needed; only the code steers the engine.
    assign status_unused = ^bus.s_tx_status_data[60:0];
    assign retry_inc     = retry_q + RW'(1);
    assign payload_ready = drain_q | (data_q & bus.m_tx_data_ready);
    assign last_beat     = (beat_cnt_q == beats_q - 10'd1);

    assign cmd_hs  = cmd_ready_q & bus.s_cmd_valid;
    assign meta_hs = meta_valid_q & bus.m_tx_meta_ready;
    assign st_hs   = status_ready_q & bus.s_tx_status_valid;
    assign pay_hs  = bus.s_payload_valid & payload_ready;
    assign done_hs = done_valid_q & bus.m_done_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_hs) state_d = (cmd_total == 32'd0) ? S_DONE : S_META;
            S_META:   if (meta_hs) state_d = S_STATUS;
            S_STATUS: begin
                if (st_hs) begin
                    if (st_code == 3'd0)
                        state_d = S_DATA;
                    else if (st_code == 3'd2)
                        state_d = (retry_inc == RW'(MAX_RETRIES)) ? S_DRAIN : S_WAIT;
                    else
                        state_d = S_DRAIN;
                end
            end
            S_WAIT:   if (backoff_q == '0) state_d = S_META;
            S_DATA: begin
                if (pay_hs && last_beat)
                    state_d = (remaining_q == 32'(pkt_len_q)) ? S_DONE : S_META;
            end
            S_DRAIN:  if (pay_hs && remaining_q <= 32'd64) state_d = S_DONE;
            S_DONE:   if (done_hs) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q        <= S_IDLE;
            session_q      <= '0;
            remaining_q    <= '0;
            sent_q         <= '0;
            pkt_len_q      <= '0;
            retry_q        <= '0;
            backoff_q      <= '0;
            beats_q        <= '0;
            beat_cnt_q     <= '0;
            err_q          <= '0;
            cmd_ready_q    <= 1'b0;
            meta_valid_q   <= 1'b0;
            status_ready_q <= 1'b0;
            data_q         <= 1'b0;
            drain_q        <= 1'b0;
            done_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= (state_d == S_IDLE);
            meta_valid_q   <= (state_d == S_META);
            status_ready_q <= (state_d == S_STATUS);
            data_q         <= (state_d == S_DATA);
            drain_q        <= (state_d == S_DRAIN);
            done_valid_q   <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (cmd_hs) begin
                        session_q   <= bus.s_cmd_data[15:0];
                        remaining_q <= cmd_total;
                        sent_q      <= '0;
                        retry_q     <= '0;
                        err_q       <= '0;
                        pkt_len_q   <= clip_len(cmd_total);
                    end
                end
                S_STATUS: begin
                    if (st_hs) begin
                        if (st_code == 3'd0) begin
                            retry_q    <= '0;
                            beats_q    <= 10'((17'(pkt_len_q) + 17'd63) >> 6);
                            beat_cnt_q <= '0;
                        end else if (st_code == 3'd2) begin
                            retry_q <= retry_inc;
                            if (retry_inc == RW'(MAX_RETRIES))
                                err_q <= 3'd2;
                            else
                                backoff_q <= BW'(RETRY_CYCLES - 1);
                        end else begin
                            err_q <= st_code;
                        end
                    end
                end
                S_WAIT: begin
                    if (backoff_q != '0) backoff_q <= backoff_q - BW'(1);
                end
                S_DATA: begin
                    if (pay_hs) begin
                        beat_cnt_q <= beat_cnt_q + 10'd1;
                        if (last_beat) begin
                            remaining_q <= remaining_q - 32'(pkt_len_q);
                            sent_q      <= sent_q + 32'(pkt_len_q);
                            pkt_len_q   <= clip_len(remaining_q - 32'(pkt_len_q));
                        end
                    end
                end
                S_DRAIN: begin
                    // Remaining counts down in whole beats so the payload stream ends aligned.
                    if (pay_hs) remaining_q <= (remaining_q > 32'd64) ? remaining_q - 32'd64 : 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_cmd_ready       = cmd_ready_q;
    assign bus.m_tx_meta_valid   = meta_valid_q;
    assign bus.m_tx_meta_data    = {pkt_len_q, session_q};
    assign bus.s_tx_status_ready = status_ready_q;
    assign bus.s_payload_ready   = payload_ready;
    assign bus.m_tx_data_valid   = data_q & bus.s_payload_valid;
    assign bus.m_tx_data_data    = data_q ? bus.s_payload_data : '0;
    assign bus.m_tx_data_last    = data_q & last_beat;
    assign bus.m_tx_data_keep    = !data_q ? 64'd0 :
                                   (last_beat && pkt_len_q[5:0] != 6'd0) ?
                                   (64'd1 << pkt_len_q[5:0]) - 64'd1 : {64{1'b1}};
    assign bus.m_done_valid      = done_valid_q;
    assign bus.m_done_data       = {13'd0, err_q, session_q, sent_q};
endmodule

// File: tb/tb_tcp_tx_packetizer.sv
// tb/tb_tcp_tx_packetizer.sv - randomized bench for tcp_tx_packetizer against a packet-level reference model
module tb_tcp_tx_packetizer;
    localparam int MAX_PKT      = 1408;
    localparam int RETRY_CYCLES = 20;
    localparam int MAX_RETRIES  = 2;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    tcp_tx_packetizer_if bus ();

    tcp_tx_packetizer #(
        .MAX_PKT(MAX_PKT), .RETRY_CYCLES(RETRY_CYCLES), .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int unsigned pay_idx = 0;
    int unsigned exp_pay_idx = 0;

    logic [2:0]  plan_q[$];
    logic [2:0]  status_q[$];
    logic [31:0] meta_got_q[$];
    int unsigned meta_rise_q[$];
    int unsigned st_cyc_q[$];
    beat_t       rx_q[$];
    logic [63:0] done_got_q[$];

    logic [31:0] exp_meta_q[$];
    beat_t       exp_beat_q[$];
    int          exp_retry_k[$];
    logic [63:0] exp_done;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] beat_data(input int unsigned idx);
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = idx * 32'h9E3779B1 + 32'(j) * 32'h01000193;
        return d;
    endfunction

    // Packet-level model: walks the command byte count and planned status codes.
    task automatic build_model(input logic [15:0] session, input logic [31:0] total);
        longint rem = longint'(total);
        longint sent = 0;
        int k = 0, retries = 0, err = 0, code, len, nb, bytes;
        beat_t b;
        exp_meta_q.delete(); exp_beat_q.delete(); exp_retry_k.delete();
        while (rem > 0 && err == 0) begin
            len = (rem > MAX_PKT) ? MAX_PKT : int'(rem);
            exp_meta_q.push_back({16'(len), session});
            code = (k < plan_q.size()) ? int'(plan_q[k]) : 0;
            k++;
            if (code == 0) begin
                retries = 0;
                nb = (len + 63) / 64;
                for (int i = 0; i < nb; i++) begin
                    bytes = (i == nb - 1) ? len - 64 * i : 64;
                    b.data = beat_data(exp_pay_idx);
                    exp_pay_idx++;
                    for (int j = 0; j < 64; j++) b.keep[j] = (j < bytes);
                    b.last = (i == nb - 1);
                    exp_beat_q.push_back(b);
                end
                rem -= len;
                sent += len;
            end else if (code == 2) begin
                retries++;
                if (retries == MAX_RETRIES) err = 2;
                else exp_retry_k.push_back(k - 1);
            end else begin
                err = code;
            end
        end
        if (err != 0) exp_pay_idx += int'((rem + 63) / 64);
        exp_done = {13'd0, 3'(err), session, 32'(sent)};
    endtask

    initial begin : payload_src
        bit hs;
        bus.s_payload_valid = 1'b0;
        bus.s_payload_data  = '0;
        forever begin
            @(negedge aclk);
            hs = bus.s_payload_valid && bus.s_payload_ready;
            @(posedge aclk); #1;
            if (hs) pay_idx++;
            if (!bus.s_payload_valid || hs) begin
                bus.s_payload_valid = ($urandom_range(0, 3) != 0);
                bus.s_payload_data  = beat_data(pay_idx);
            end
        end
    end

    initial begin : tx_sink
        beat_t b;
        bus.m_tx_data_ready = 1'b0;
        forever begin
            @(negedge aclk);
            if (bus.m_tx_data_valid && bus.m_tx_data_ready) begin
                b.data = bus.m_tx_data_data;
                b.keep = bus.m_tx_data_keep;
                b.last = bus.m_tx_data_last;
                rx_q.push_back(b);
            end
            @(posedge aclk); #1;
            bus.m_tx_data_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : net_side
        bit meta_hs, st_hs, pending, meta_prev;
        int dly;
        logic [2:0] code;
        pending = 0; meta_prev = 0; dly = 0;
        bus.m_tx_meta_ready   = 1'b0;
        bus.s_tx_status_valid = 1'b0;
        bus.s_tx_status_data  = '0;
        forever begin
            @(negedge aclk);
            meta_hs = bus.m_tx_meta_valid && bus.m_tx_meta_ready;
            st_hs   = bus.s_tx_status_valid && bus.s_tx_status_ready;
            if (bus.m_tx_meta_valid && !meta_prev) meta_rise_q.push_back(cyc);
            meta_prev = bus.m_tx_meta_valid;
            if (meta_hs) meta_got_q.push_back(bus.m_tx_meta_data);
            if (st_hs) st_cyc_q.push_back(cyc);
            @(posedge aclk); #1;
            if (!aresetn) begin
                pending = 0;
                bus.s_tx_status_valid = 1'b0;
                bus.m_tx_meta_ready   = 1'b0;
            end else begin
                if (st_hs) bus.s_tx_status_valid = 1'b0;
                if (meta_hs) begin
                    pending = 1;
                    dly = $urandom_range(0, 3);
                end
                if (pending && !bus.s_tx_status_valid) begin
                    if (dly == 0) begin
                        code = (status_q.size() > 0) ? status_q.pop_front() : 3'd0;
                        bus.s_tx_status_data  = {code, 29'($urandom), 32'($urandom)};
                        bus.s_tx_status_valid = 1'b1;
                        pending = 0;
                    end else begin
                        dly--;
                    end
                end
                bus.m_tx_meta_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin : done_sink
        bus.m_done_ready = 1'b0;
        forever begin
            @(negedge aclk);
            if (bus.m_done_valid && bus.m_done_ready) done_got_q.push_back(bus.m_done_data);
            @(posedge aclk); #1;
            bus.m_done_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic clear_obs();
        meta_got_q.delete(); meta_rise_q.delete(); st_cyc_q.delete();
        rx_q.delete(); done_got_q.delete();
    endtask

    task automatic issue_cmd(input logic [15:0] session, input logic [31:0] total,
                             input string tag, output int unsigned acc_cyc);
        int budget = 0;
        @(posedge aclk); #1;
        bus.s_cmd_valid = 1'b1;
        bus.s_cmd_data  = {total, session};
        do begin
            @(negedge aclk);
            budget++;
        end while (!bus.s_cmd_ready && budget < 200);
        acc_cyc = cyc;
        check({tag, ".cmd_accept"}, 512'(bus.s_cmd_ready), 512'(1));
        @(posedge aclk); #1;
        bus.s_cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [15:0] session, input logic [31:0] total, input string tag);
        int unsigned acc_cyc;
        int budget = 0;
        int k;
        build_model(session, total);
        status_q = plan_q;
        clear_obs();
        issue_cmd(session, total, tag, acc_cyc);
        while (done_got_q.size() == 0 && budget < 20000) begin
            @(negedge aclk);
            budget++;
        end
        check({tag, ".done_cnt"}, 512'(done_got_q.size()), 512'(1));
        if (done_got_q.size() > 0) check({tag, ".done"}, 512'(done_got_q[0]), 512'(exp_done));
        check({tag, ".meta_cnt"}, 512'(meta_got_q.size()), 512'(exp_meta_q.size()));
        for (int i = 0; i < meta_got_q.size() && i < exp_meta_q.size(); i++)
            check($sformatf("%s.meta%0d", tag, i), 512'(meta_got_q[i]), 512'(exp_meta_q[i]));
        check({tag, ".beat_cnt"}, 512'(rx_q.size()), 512'(exp_beat_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_beat_q.size(); i++) begin
            check($sformatf("%s.data%0d", tag, i), rx_q[i].data, exp_beat_q[i].data);
            check($sformatf("%s.keeplast%0d", tag, i), 512'({rx_q[i].last, rx_q[i].keep}),
                  512'({exp_beat_q[i].last, exp_beat_q[i].keep}));
        end
        if (exp_meta_q.size() > 0 && meta_rise_q.size() > 0)
            check({tag, ".meta_lat"}, 512'(meta_rise_q[0] - acc_cyc), 512'(1));
        foreach (exp_retry_k[r]) begin
            k = exp_retry_k[r];
            if (k < st_cyc_q.size() && k + 1 < meta_rise_q.size())
                check($sformatf("%s.backoff%0d", tag, k), 512'(meta_rise_q[k+1] - st_cyc_q[k]),
                      512'(RETRY_CYCLES + 1));
            else
                check($sformatf("%s.backoff%0d_seen", tag, k), 512'(0), 512'(1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 512'({bus.s_cmd_ready, bus.m_tx_meta_valid, bus.s_tx_status_ready,
                         bus.s_payload_ready, bus.m_tx_data_valid, bus.m_tx_data_last,
                         bus.m_done_valid, bus.m_tx_data_keep, bus.m_tx_meta_data, bus.m_done_data}),
              512'(0));
    endtask

    task automatic reset_and_release(input string tag);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_all_zero({tag, ".in_reset"});
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check({tag, ".ready_after_rst"}, 512'(bus.s_cmd_ready), 512'(0));
        @(negedge aclk);
        check({tag, ".idle_ready"}, 512'(bus.s_cmd_ready), 512'(1));
        status_q.delete();
        clear_obs();
        exp_pay_idx = pay_idx;
    endtask

    initial begin : main
        int unsigned pay0, acc_cyc;
        int budget, sel, p;
        logic [31:0] total;
        bus.s_cmd_valid = 1'b0;
        bus.s_cmd_data  = '0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_all_zero("por.in_reset");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("por.ready_after_rst", 512'(bus.s_cmd_ready), 512'(0));
        @(negedge aclk);
        check("por.idle_ready", 512'(bus.s_cmd_ready), 512'(1));
        exp_pay_idx = pay_idx;

        plan_q.delete(); plan_q.push_back(3'd0);
        run_cmd(16'd5, 32'd100, "single");
        if (meta_got_q.size() > 0) check("single.meta_const", 512'(meta_got_q[0]), 512'({16'd100, 16'd5}));
        if (rx_q.size() == 2) check("single.keep_const", 512'(rx_q[1].keep), 512'(64'hF_FFFF_FFFF));
        if (done_got_q.size() > 0)
            check("single.done_const", 512'(done_got_q[0]), 512'({13'd0, 3'd0, 16'd5, 32'd100}));

        plan_q.delete();
        run_cmd(16'd7, 32'd3000, "multi");
        if (meta_got_q.size() == 3)
            check("multi.lens", 512'({meta_got_q[0][31:16], meta_got_q[1][31:16], meta_got_q[2][31:16]}),
                  512'({16'd1408, 16'd1408, 16'd184}));
        if (rx_q.size() == 47) check("multi.last_keep", 512'(rx_q[46].keep), 512'(64'hFF_FFFF_FFFF_FFFF));

        plan_q.delete(); plan_q.push_back(3'd2); plan_q.push_back(3'd0);
        run_cmd(16'd3, 32'd500, "retry");

        plan_q.delete(); plan_q.push_back(3'd0); plan_q.push_back(3'd1);
        pay0 = pay_idx;
        run_cmd(16'd11, 32'd3000, "fatal");
        check("fatal.consumed", 512'(pay_idx - pay0), 512'(47));
        if (done_got_q.size() > 0)
            check("fatal.done_const", 512'(done_got_q[0]), 512'({13'd0, 3'd1, 16'd11, 32'd1408}));

        plan_q.delete(); plan_q.push_back(3'd2); plan_q.push_back(3'd2);
        run_cmd(16'd12, 32'd200, "exhaust");
        if (done_got_q.size() > 0)
            check("exhaust.done_const", 512'(done_got_q[0]), 512'({13'd0, 3'd2, 16'd12, 32'd0}));

        plan_q.delete();
        run_cmd(16'd13, 32'd0, "zero");
        if (done_got_q.size() > 0)
            check("zero.done_const", 512'(done_got_q[0]), 512'({13'd0, 3'd0, 16'd13, 32'd0}));

        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) total = 32'd0;
            else if (sel == 1) total = 32'($urandom_range(1, 64));
            else if (sel == 2) total = 32'(MAX_PKT * $urandom_range(1, 3));
            else total = 32'($urandom_range(1, 4500));
            plan_q.delete();
            for (int c = 0; c < 6; c++) begin
                p = $urandom_range(0, 19);
                if (p < 14) plan_q.push_back(3'd0);
                else if (p < 18) plan_q.push_back(3'd2);
                else plan_q.push_back((p == 18) ? 3'd1 : 3'($urandom_range(3, 7)));
            end
            run_cmd(16'($urandom), total, $sformatf("rnd%0d", n));
        end

        status_q.delete();
        clear_obs();
        issue_cmd(16'd9, 32'd3000, "rstcmd", acc_cyc);
        budget = 0;
        while (rx_q.size() < 3 && budget < 5000) begin
            @(negedge aclk);
            budget++;
        end
        check("rstcmd.in_data", 512'(rx_q.size() >= 3), 512'(1));
        reset_and_release("midrst");

        plan_q.delete();
        run_cmd(16'd21, 32'd777, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
